// File: rtl/uart_tx_sched.sv
// Round-robin transmit scheduler sharing one UART transmitter core among
// N_REQ byte producers. One byte is accepted per valid/ready handshake, then
// the core is sequenced: data presented, one-cycle start strobe, wait for
// busy to rise, wait for busy to fall.
//
// state        | meaning
// -------------+--------------------------------------------------------------
// S_IDLE       | waiting for an enabled, idle core and at least one request
// S_START      | byte latched on tx_data_out, start strobe issued this cycle
// S_WAIT_BUSY  | waiting for the core to raise busy (timeout / abort guarded)
// S_WAIT_DONE  | core owns the frame, waiting for busy to fall
module uart_tx_sched #(
   parameter int N_REQ        = 4,
   parameter int BUSY_TIMEOUT = 255
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic [N_REQ-1:0]                          req_valid,
   input  logic [8*N_REQ-1:0]                        req_data,
   output logic [N_REQ-1:0]                          req_ready,
   input  logic                                      uart_en_in,
   input  logic                                      tx_busy_in,
   output logic [7:0]                                tx_data_out,
   output logic                                      tx_start_out,
   output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] grant_id_out,
   output logic                                      sched_busy_out,
   output logic                                      timeout_out,
   output logic                                      abort_out
);

   localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CW = (BUSY_TIMEOUT > 0) ? $clog2(BUSY_TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_START     = 2'd1,
      S_WAIT_BUSY = 2'd2,
      S_WAIT_DONE = 2'd3
   } state_t;

   state_t          r_state;
   logic [GW-1:0]   r_rr_ptr;
   logic [GW-1:0]   r_grant;
   logic [7:0]      r_tx_data;
   logic [CW-1:0]   r_cnt;
   logic            r_timeout;
   logic            r_abort;

   logic            w_found;
   logic [GW-1:0]   w_gnt;
   logic [GW:0]     w_sum;
   logic [GW-1:0]   w_idx;
   logic [7:0]      w_data;
   logic            w_accept;
   logic [N_REQ-1:0] w_ready;

   // Round-robin search: first valid requester after the last winner, wrapping.
   always_comb begin
      w_found = 1'b0;
      w_gnt   = '0;
      w_sum   = '0;
      w_idx   = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         w_sum = {1'b0, r_rr_ptr} + (GW+1)'(k);
         if (w_sum >= (GW+1)'(N_REQ)) begin
            w_sum = w_sum - (GW+1)'(N_REQ);
         end
         w_idx = w_sum[GW-1:0];
         if (!w_found && req_valid[w_idx]) begin
            w_found = 1'b1;
            w_gnt   = w_idx;
         end
      end
   end

   // Handshake is only offered when the core is enabled and idle.
   assign w_accept = (r_state == S_IDLE) & uart_en_in & ~tx_busy_in & w_found;

   // Byte mux and one-hot ready for the selected requester.
   always_comb begin
      w_data  = '0;
      w_ready = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_gnt == GW'(i)) begin
            w_data     = req_data[8*i +: 8];
            w_ready[i] = w_accept;
         end
      end
   end

   // Sequencer: latches the accepted byte and walks the core handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_rr_ptr  <= GW'(N_REQ - 1);
         r_grant   <= '0;
         r_tx_data <= '0;
         r_cnt     <= '0;
         r_timeout <= 1'b0;
         r_abort   <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         r_abort   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_tx_data <= w_data;
                  r_grant   <= w_gnt;
                  r_rr_ptr  <= w_gnt;
                  r_state   <= S_START;
               end
            end
            S_START: begin
               if (uart_en_in) begin
                  r_cnt   <= '0;
                  r_state <= S_WAIT_BUSY;
               end else begin
                  r_abort <= 1'b1;
                  r_state <= S_IDLE;
               end
            end
            S_WAIT_BUSY: begin
               // Busy rising takes priority over both abort and timeout.
               if (tx_busy_in) begin
                  r_state <= S_WAIT_DONE;
               end else if (!uart_en_in) begin
                  r_abort <= 1'b1;
                  r_state <= S_IDLE;
               end else if (r_cnt == CW'(BUSY_TIMEOUT - 1)) begin
                  r_timeout <= 1'b1;
                  r_state   <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_WAIT_DONE: begin
               // Enable is ignored here: the core owns the frame once started.
               if (!tx_busy_in) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign req_ready      = w_ready;
   assign tx_data_out    = r_tx_data;
   assign grant_id_out   = r_grant;
   assign tx_start_out   = (r_state == S_START) & uart_en_in;
   assign sched_busy_out = (r_state != S_IDLE);
   assign timeout_out    = r_timeout;
   assign abort_out      = r_abort;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: stimulus pushes expected core-facing
// events (start strobe with byte/grant, timeout pulse, abort pulse); a monitor
// pops and compares whenever the DUT produces one of them.
module tb_uart_tx_sched;
   localparam int N = 4;
   localparam int T = 8;

   logic            clk;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [8*N-1:0]  req_data;
   logic [N-1:0]    req_ready;
   logic            uart_en_in;
   logic            tx_busy_in;
   logic [7:0]      tx_data_out;
   logic            tx_start_out;
   logic [1:0]      grant_id_out;
   logic            sched_busy_out;
   logic            timeout_out;
   logic            abort_out;

   logic            core_auto;
   logic            core_busy;
   logic            man_busy;
   int              frame_len;

   typedef struct {
      int         kind;
      logic [7:0] data;
      int         gid;
   } exp_t;

   localparam int K_START   = 0;
   localparam int K_TIMEOUT = 1;
   localparam int K_ABORT   = 2;

   exp_t exp_q[$];
   int   n_pass;
   int   n_total;
   int   grant_cnt [N];

   assign tx_busy_in = core_auto ? core_busy : man_busy;

   uart_tx_sched #(.N_REQ(N), .BUSY_TIMEOUT(T)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_data       (req_data),
      .req_ready      (req_ready),
      .uart_en_in     (uart_en_in),
      .tx_busy_in     (tx_busy_in),
      .tx_data_out    (tx_data_out),
      .tx_start_out   (tx_start_out),
      .grant_id_out   (grant_id_out),
      .sched_busy_out (sched_busy_out),
      .timeout_out    (timeout_out),
      .abort_out      (abort_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic void push_ev(input int kind, input logic [7:0] d, input int g);
      exp_t e;
      e.kind = kind;
      e.data = d;
      e.gid  = g;
      exp_q.push_back(e);
   endfunction

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input int idx, input logic [7:0] d);
      req_data  = (req_data & ~(32'hFF << (8*idx))) | (32'(d) << (8*idx));
      req_valid = req_valid | (4'b1 << idx);
   endtask

   task automatic withdraw(input int idx);
      req_valid = req_valid & ~(4'b1 << idx);
   endtask

   // Returns #1 after the accepting edge (scheduler then in START).
   task automatic wait_accept(input int idx);
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         if (((req_ready >> idx) & 4'b1) != 4'b0) begin
            ok = 1'b1;
            break;
         end
      end
      chk("accept_seen", 32'(ok), 32'd1);
      if (ok) begin
         chk("ready_onehot", 32'(req_ready), 32'(4'b1 << idx));
         sync();
         chk("ready_drop", 32'(req_ready), 32'd0);
      end
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (!sched_busy_out) begin
            ok = 1'b1;
            break;
         end
      end
      chk("idle_reached", 32'(ok), 32'd1);
   endtask

   // Simple UART core model: busy rises the cycle after the strobe, lasts frame_len cycles.
   initial begin : core_model
      core_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (core_auto && tx_start_out && !rst) begin
            @(posedge clk);
            #1 core_busy = 1'b1;
            repeat (frame_len) @(posedge clk);
            #1 core_busy = 1'b0;
         end
      end
   end

   initial begin : monitor
      exp_t e;
      int   obs;
      forever begin
         @(negedge clk);
         if (!rst && (tx_start_out || timeout_out || abort_out)) begin
            obs = tx_start_out ? K_START : (timeout_out ? K_TIMEOUT : K_ABORT);
            chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("event_kind", 32'(obs), 32'(e.kind));
               if (obs == K_START && e.kind == K_START) begin
                  chk("tx_data", 32'(tx_data_out), 32'(e.data));
                  chk("grant_id", 32'(grant_id_out), 32'(e.gid));
               end
            end
            if (tx_start_out) grant_cnt[grant_id_out]++;
         end
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int tk;
      int cnt;
      int ab;
      bit ok;
      n_pass = 0;
      n_total = 0;
      for (int i = 0; i < N; i++) grant_cnt[i] = 0;
      rst = 1'b1;
      req_valid = 4'b1111;
      req_data = '0;
      uart_en_in = 1'b0;
      man_busy = 1'b0;
      core_auto = 1'b1;
      frame_len = 10;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state; enable low so no request can be taken.
      @(negedge clk);
      chk("rst_start", 32'(tx_start_out), 32'd0);
      chk("rst_timeout", 32'(timeout_out), 32'd0);
      chk("rst_abort", 32'(abort_out), 32'd0);
      chk("rst_sched_busy", 32'(sched_busy_out), 32'd0);
      chk("rst_grant", 32'(grant_id_out), 32'd0);
      chk("rst_data", 32'(tx_data_out), 32'd0);
      chk("rst_ready_en0", 32'(req_ready), 32'd0);

      // Single request, 10-cycle frame: START + WAIT_BUSY + 10 = 12 busy cycles.
      sync();
      req_valid = '0;
      uart_en_in = 1'b1;
      offer(0, 8'hA5);
      push_ev(K_START, 8'hA5, 0);
      wait_accept(0);
      withdraw(0);
      chk("single_start", 32'(tx_start_out), 32'd1);
      chk("single_data", 32'(tx_data_out), 32'hA5);
      cnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (sched_busy_out) cnt++;
         else break;
      end
      chk("single_busy_len", 32'(cnt), 32'd12);

      // Fairness from reset: all valid, 3-cycle frames -> 0,1,2,3,0.
      sync();
      rst = 1'b1;
      sync();
      rst = 1'b0;
      for (int i = 0; i < N; i++) grant_cnt[i] = 0;
      frame_len = 3;
      for (int i = 0; i < N; i++) offer(i, 8'h10 + 8'(i));
      push_ev(K_START, 8'h10, 0);
      push_ev(K_START, 8'h11, 1);
      push_ev(K_START, 8'h12, 2);
      push_ev(K_START, 8'h13, 3);
      push_ev(K_START, 8'h10, 0);
      wait_accept(0);
      wait_accept(1);
      wait_accept(2);
      wait_accept(3);
      wait_accept(0);
      req_valid = '0;
      wait_idle();
      chk("fair_cnt0", 32'(grant_cnt[0]), 32'd2);
      chk("fair_cnt1", 32'(grant_cnt[1]), 32'd1);
      chk("fair_cnt2", 32'(grant_cnt[2]), 32'd1);
      chk("fair_cnt3", 32'(grant_cnt[3]), 32'd1);

      // Timeout: busy never rises; pulse 1 + T cycles after the START cycle.
      sync();
      core_auto = 1'b0;
      man_busy = 1'b0;
      offer(1, 8'h3C);
      push_ev(K_START, 8'h3C, 1);
      push_ev(K_TIMEOUT, 8'h00, 0);
      wait_accept(1);
      withdraw(1);
      tk = -1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (timeout_out) begin
            tk = k;
            break;
         end
      end
      chk("timeout_cycle", 32'(tk), 32'd9);
      chk("timeout_idle", 32'(sched_busy_out), 32'd0);

      // After timeout rr_ptr=1: requesters 1 and 2 pending -> 2 first, then 1.
      sync();
      core_auto = 1'b1;
      offer(1, 8'h4B);
      offer(2, 8'h5A);
      push_ev(K_START, 8'h5A, 2);
      push_ev(K_START, 8'h4B, 1);
      wait_accept(2);
      withdraw(2);
      wait_accept(1);
      withdraw(1);
      wait_idle();

      // Abort: enable drops during START; no strobe, one abort, no ready while disabled.
      sync();
      offer(3, 8'h77);
      push_ev(K_ABORT, 8'h00, 0);
      wait_accept(3);
      uart_en_in = 1'b0;
      ab = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (abort_out) ab++;
         chk("abort_ready_low", 32'(req_ready), 32'd0);
      end
      chk("abort_once", 32'(ab), 32'd1);
      chk("abort_idle", 32'(sched_busy_out), 32'd0);
      sync();
      push_ev(K_START, 8'h77, 3);
      uart_en_in = 1'b1;
      wait_accept(3);
      withdraw(3);
      wait_idle();

      // Gating: core busy in IDLE blocks ready.
      sync();
      core_auto = 1'b0;
      man_busy = 1'b1;
      offer(0, 8'h11);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("gate_ready_low", 32'(req_ready), 32'd0);
      end
      sync();
      push_ev(K_START, 8'h11, 0);
      man_busy = 1'b0;
      wait_accept(0);
      withdraw(0);
      // Busy rise and enable drop in the same WAIT_BUSY cycle: busy wins.
      sync();
      man_busy = 1'b1;
      uart_en_in = 1'b0;
      sync();
      chk("busy_wins_1", 32'(sched_busy_out), 32'd1);
      sync();
      chk("busy_wins_2", 32'(sched_busy_out), 32'd1);
      man_busy = 1'b0;
      sync();
      chk("busy_wins_idle", 32'(sched_busy_out), 32'd0);
      uart_en_in = 1'b1;
      core_auto = 1'b1;

      // Reset in WAIT_DONE: outputs clear and requester 0 wins next.
      frame_len = 10;
      offer(2, 8'h99);
      push_ev(K_START, 8'h99, 2);
      wait_accept(2);
      withdraw(2);
      sync();
      sync();
      chk("rst2_in_done", 32'(sched_busy_out), 32'd1);
      rst = 1'b1;
      sync();
      rst = 1'b0;
      chk("rst2_sched_busy", 32'(sched_busy_out), 32'd0);
      chk("rst2_data", 32'(tx_data_out), 32'd0);
      chk("rst2_grant", 32'(grant_id_out), 32'd0);
      chk("rst2_start", 32'(tx_start_out), 32'd0);
      ok = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (!tx_busy_in) begin
            ok = 1'b1;
            break;
         end
         sync();
      end
      chk("rst2_core_free", 32'(ok), 32'd1);
      offer(3, 8'hC3);
      offer(0, 8'h0F);
      push_ev(K_START, 8'h0F, 0);
      push_ev(K_START, 8'hC3, 3);
      wait_accept(0);
      withdraw(0);
      wait_accept(3);
      withdraw(3);
      wait_idle();

      repeat (3) @(negedge clk);
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
